// File: rtl/shift_arbiter_pkg.sv
// Shared widths, FSM state type and requester IDs for the shift arbiter.
package shift_arbiter_pkg;

    localparam int unsigned DATA_W  = 32;
    localparam int unsigned SHAMT_W = 5;

    typedef enum logic {
        IDLE = 1'b0,
        RESP = 1'b1
    } state_t;

    localparam logic REQ0 = 1'b0;
    localparam logic REQ1 = 1'b1;

endpackage

// File: rtl/shift_arbiter_if.sv
// Requester/consumer handshake bundle of the shift arbiter.
interface shift_arbiter_if;
    import shift_arbiter_pkg::*;

    logic               req0_valid;
    logic [DATA_W-1:0]  req0_data;
    logic [SHAMT_W-1:0] req0_shamt;
    logic               req0_ready;

    logic               req1_valid;
    logic [DATA_W-1:0]  req1_data;
    logic [SHAMT_W-1:0] req1_shamt;
    logic               req1_ready;

    logic               rsp_valid;
    logic               rsp_id;
    logic [DATA_W-1:0]  rsp_result;
    logic               rsp_ready;

    modport master (
        output req0_valid, req0_data, req0_shamt,
        output req1_valid, req1_data, req1_shamt,
        output rsp_ready,
        input  req0_ready, req1_ready,
        input  rsp_valid, rsp_id, rsp_result
    );

    modport slave (
        input  req0_valid, req0_data, req0_shamt,
        input  req1_valid, req1_data, req1_shamt,
        input  rsp_ready,
        output req0_ready, req1_ready,
        output rsp_valid, rsp_id, rsp_result
    );

endinterface

// File: rtl/shift_arbiter_left_shifter.sv
// Combinational 32-bit logical left shifter, zero fill from the LSB.
module left_shifter
    import shift_arbiter_pkg::*;
(
    output logic [DATA_W-1:0]  result,
    input  logic [DATA_W-1:0]  data,
    input  logic [SHAMT_W-1:0] shiftamt
);

    assign result = data << shiftamt;

endmodule

// File: rtl/shift_arbiter.sv
// Round-robin sharing of one left_shifter between two requesters, with a
// registered response slot and saturating per-requester grant counters.
module shift_arbiter
    import shift_arbiter_pkg::*;
#(
    parameter int unsigned CNT_W = 16
) (
    input  logic             clock,
    input  logic             reset,
    shift_arbiter_if.slave   bus,
    output logic [CNT_W-1:0] grant_cnt0,
    output logic [CNT_W-1:0] grant_cnt1
);

    state_t             state;
    logic               last_grant;
    logic               rsp_valid_q;
    logic               rsp_id_q;
    logic [DATA_W-1:0]  rsp_result_q;

    logic               accept_ok;
    logic               winner;
    logic               ready0;
    logic               ready1;
    logic               xfer;
    logic [DATA_W-1:0]  mux_data;
    logic [SHAMT_W-1:0] mux_shamt;
    logic [DATA_W-1:0]  shift_out;

    always_comb begin
        accept_ok = (state == IDLE) || ((state == RESP) && bus.rsp_ready);
        if (bus.req0_valid && bus.req1_valid)
            winner = (last_grant == REQ0) ? REQ1 : REQ0;
        else if (bus.req1_valid)
            winner = REQ1;
        else
            winner = REQ0;
        // readies are held low while reset is asserted, even from IDLE
        ready0    = !reset && accept_ok && bus.req0_valid && (winner == REQ0);
        ready1    = !reset && accept_ok && bus.req1_valid && (winner == REQ1);
        xfer      = ready0 || ready1;
        mux_data  = (winner == REQ1) ? bus.req1_data  : bus.req0_data;
        mux_shamt = (winner == REQ1) ? bus.req1_shamt : bus.req0_shamt;
    end

    left_shifter u_shifter (
        .result   (shift_out),
        .data     (mux_data),
        .shiftamt (mux_shamt)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state        <= IDLE;
            rsp_valid_q  <= 1'b0;
            rsp_id_q     <= REQ0;
            rsp_result_q <= '0;
            last_grant   <= REQ1;
            grant_cnt0   <= '0;
            grant_cnt1   <= '0;
        end else if (xfer) begin
            state        <= RESP;
            rsp_valid_q  <= 1'b1;
            rsp_id_q     <= winner;
            rsp_result_q <= shift_out;
            last_grant   <= winner;
            if (ready0 && (grant_cnt0 != '1))
                grant_cnt0 <= grant_cnt0 + CNT_W'(1);
            if (ready1 && (grant_cnt1 != '1))
                grant_cnt1 <= grant_cnt1 + CNT_W'(1);
        end else if ((state == RESP) && bus.rsp_ready) begin
            state       <= IDLE;
            rsp_valid_q <= 1'b0;
        end
    end

    assign bus.req0_ready = ready0;
    assign bus.req1_ready = ready1;
    assign bus.rsp_valid  = rsp_valid_q;
    assign bus.rsp_id     = rsp_id_q;
    assign bus.rsp_result = rsp_result_q;

endmodule

// File: tb/tb_shift_arbiter.sv
// Self-checking bench for shift_arbiter against a transaction-level model.
module tb_shift_arbiter;

    localparam int unsigned CNT_W   = 4;
    localparam int          CNT_MAX = (1 << CNT_W) - 1;

    logic             clock = 1'b0;
    logic             reset;
    logic [CNT_W-1:0] grant_cnt0;
    logic [CNT_W-1:0] grant_cnt1;

    shift_arbiter_if bus();

    shift_arbiter #(.CNT_W(CNT_W)) dut (
        .clock      (clock),
        .reset      (reset),
        .bus        (bus),
        .grant_cnt0 (grant_cnt0),
        .grant_cnt1 (grant_cnt1)
    );

    always #5 clock = ~clock;

    int checks   = 0;
    int failures = 0;

    // model: response slot contents, round-robin pointer, grant counts
    bit          m_valid;
    bit          m_id;
    logic [31:0] m_result;
    bit          m_last;
    int          m_cnt0;
    int          m_cnt1;
    bit          exp_rdy0;
    bit          exp_rdy1;
    logic        obs_rdy0;
    logic        obs_rdy1;

    function automatic logic [31:0] ref_shift(input logic [31:0] d, input logic [4:0] s);
        logic [63:0] p;
        p = {32'd0, d} * (64'd1 << s);
        return p[31:0];
    endfunction

    task automatic model_reset();
        m_valid  = 1'b0;
        m_id     = 1'b0;
        m_result = '0;
        m_last   = 1'b1;
        m_cnt0   = 0;
        m_cnt1   = 0;
    endtask

    task automatic set_in(input bit v0, input logic [31:0] d0, input logic [4:0] s0,
                          input bit v1, input logic [31:0] d1, input logic [4:0] s1,
                          input bit rr);
        bus.req0_valid = v0;
        bus.req0_data  = d0;
        bus.req0_shamt = s0;
        bus.req1_valid = v1;
        bus.req1_data  = d1;
        bus.req1_shamt = s1;
        bus.rsp_ready  = rr;
    endtask

    // Called at posedge+1; samples readies mid-cycle, advances model at the edge.
    task automatic step();
        bit          v0, v1, rr, take;
        logic [31:0] d0, d1;
        logic [4:0]  s0, s1;
        #2;
        v0 = bus.req0_valid; d0 = bus.req0_data; s0 = bus.req0_shamt;
        v1 = bus.req1_valid; d1 = bus.req1_data; s1 = bus.req1_shamt;
        rr = bus.rsp_ready;
        take = !m_valid || rr;
        exp_rdy0 = 1'b0;
        exp_rdy1 = 1'b0;
        if (take) begin
            if (v0 && v1) begin
                if (m_last) exp_rdy0 = 1'b1;
                else        exp_rdy1 = 1'b1;
            end else if (v0) exp_rdy0 = 1'b1;
            else if (v1)     exp_rdy1 = 1'b1;
        end
        obs_rdy0 = bus.req0_ready;
        obs_rdy1 = bus.req1_ready;
        @(posedge clock);
        if (exp_rdy0) begin
            m_valid = 1'b1; m_id = 1'b0; m_result = ref_shift(d0, s0); m_last = 1'b0;
            if (m_cnt0 < CNT_MAX) m_cnt0++;
        end else if (exp_rdy1) begin
            m_valid = 1'b1; m_id = 1'b1; m_result = ref_shift(d1, s1); m_last = 1'b1;
            if (m_cnt1 < CNT_MAX) m_cnt1++;
        end else if (m_valid && rr) begin
            m_valid = 1'b0;
        end
        #1;
    endtask

    task automatic drain();
        set_in(0, '0, '0, 0, '0, '0, 1);
        step();
    endtask

    task automatic test_reset();
        reset = 1'b1;
        set_in(1, 32'h1234_5678, 5'd3, 1, 32'h1, 5'd1, 1);
        model_reset();
        repeat (2) @(posedge clock);
        #1;
        checks++; if (bus.req0_ready !== 1'b0 || bus.req1_ready !== 1'b0) begin failures++;
            $display("FAIL reset_ready: got %b%b expected 00", bus.req0_ready, bus.req1_ready); end
        checks++; if (bus.rsp_valid !== 1'b0) begin failures++;
            $display("FAIL reset_rsp_valid: got %b expected 0", bus.rsp_valid); end
        checks++; if (bus.rsp_id !== 1'b0 || bus.rsp_result !== 32'h0) begin failures++;
            $display("FAIL reset_rsp: got id=%b result=%h expected id=0 result=00000000", bus.rsp_id, bus.rsp_result); end
        checks++; if (grant_cnt0 !== '0 || grant_cnt1 !== '0) begin failures++;
            $display("FAIL reset_cnt: got %h/%h expected 0/0", grant_cnt0, grant_cnt1); end
        reset = 1'b0;
        set_in(0, '0, '0, 0, '0, '0, 1);
    endtask

    task automatic test_single();
        set_in(1, 32'h0000_ffff, 5'd16, 0, '0, '0, 1);
        step();
        checks++; if (obs_rdy0 !== 1'b1 || obs_rdy1 !== 1'b0) begin failures++;
            $display("FAIL single_ready: got %b%b expected 10", obs_rdy0, obs_rdy1); end
        set_in(0, '0, '0, 0, '0, '0, 1);
        checks++; if (bus.rsp_valid !== 1'b1 || bus.rsp_id !== 1'b0) begin failures++;
            $display("FAIL single_rsp: got valid=%b id=%b expected valid=1 id=0", bus.rsp_valid, bus.rsp_id); end
        checks++; if (bus.rsp_result !== 32'hffff_0000) begin failures++;
            $display("FAIL single_result: got %h expected ffff0000", bus.rsp_result); end
        checks++; if (grant_cnt0 !== 4'd1) begin failures++;
            $display("FAIL single_cnt0: got %0d expected 1", grant_cnt0); end
        drain();
    endtask

    task automatic test_contention();
        bit prev_id;
        set_in(1, 32'h0000_ffff, 5'd16, 1, 32'h0000_ffff, 5'd17, 1);
        for (int i = 0; i < 6; i++) begin
            step();
            checks++; if (obs_rdy0 !== exp_rdy0 || obs_rdy1 !== exp_rdy1) begin failures++;
                $display("FAIL contention_ready[%0d]: got %b%b expected %b%b", i, obs_rdy0, obs_rdy1, exp_rdy0, exp_rdy1); end
            checks++; if (bus.rsp_valid !== 1'b1 || bus.rsp_id !== m_id) begin failures++;
                $display("FAIL contention_id[%0d]: got valid=%b id=%b expected valid=1 id=%b", i, bus.rsp_valid, bus.rsp_id, m_id); end
            checks++; if (bus.rsp_result !== (m_id ? 32'hfffe_0000 : 32'hffff_0000)) begin failures++;
                $display("FAIL contention_result[%0d]: got %h expected %h", i, bus.rsp_result, m_result); end
            if (i > 0) begin
                checks++; if (m_id == prev_id) begin failures++;
                    $display("FAIL contention_alternate[%0d]: got id=%b twice expected alternation", i, m_id); end
            end
            prev_id = m_id;
        end
        drain();
    endtask

    task automatic test_backpressure();
        set_in(0, '0, '0, 1, 32'h0000_0001, 5'd31, 1);
        step();
        set_in(1, 32'h1234_5678, 5'd3, 0, '0, '0, 0);
        for (int i = 0; i < 3; i++) begin
            step();
            checks++; if (obs_rdy0 !== 1'b0) begin failures++;
                $display("FAIL stall_ready0[%0d]: got %b expected 0", i, obs_rdy0); end
            checks++; if (bus.rsp_valid !== 1'b1 || bus.rsp_id !== 1'b1 || bus.rsp_result !== 32'h8000_0000) begin failures++;
                $display("FAIL stall_hold[%0d]: got valid=%b id=%b result=%h expected 1 1 80000000", i, bus.rsp_valid, bus.rsp_id, bus.rsp_result); end
        end
        bus.rsp_ready = 1'b1;
        step();
        checks++; if (obs_rdy0 !== 1'b1) begin failures++;
            $display("FAIL release_ready0: got %b expected 1", obs_rdy0); end
        checks++; if (bus.rsp_valid !== 1'b1 || bus.rsp_id !== 1'b0 || bus.rsp_result !== 32'h91a2_b3c0) begin failures++;
            $display("FAIL release_rsp: got valid=%b id=%b result=%h expected 1 0 91a2b3c0", bus.rsp_valid, bus.rsp_id, bus.rsp_result); end
        drain();
    endtask

    task automatic test_edges();
        set_in(0, '0, '0, 1, 32'hdead_beef, 5'd0, 1);
        step();
        checks++; if (bus.rsp_result !== 32'hdead_beef) begin failures++;
            $display("FAIL shamt0: got %h expected deadbeef", bus.rsp_result); end
        set_in(1, 32'hf000_0000, 5'd4, 0, '0, '0, 1);
        step();
        checks++; if (bus.rsp_result !== 32'h0000_0000) begin failures++;
            $display("FAIL shamt4_overflow: got %h expected 00000000", bus.rsp_result); end
        set_in(0, '0, '0, 1, 32'hffff_fffe, 5'd31, 1);
        step();
        checks++; if (bus.rsp_result !== 32'h0000_0000) begin failures++;
            $display("FAIL shamt31_lsb0: got %h expected 00000000", bus.rsp_result); end
        drain();
    endtask

    task automatic test_reset_mid();
        set_in(1, 32'h0000_00ff, 5'd8, 0, '0, '0, 0);
        step();
        #1;
        reset = 1'b1;
        #1;
        checks++; if (bus.rsp_valid !== 1'b0 || bus.rsp_id !== 1'b0 || bus.rsp_result !== 32'h0) begin failures++;
            $display("FAIL async_reset_rsp: got valid=%b id=%b result=%h expected 0 0 00000000", bus.rsp_valid, bus.rsp_id, bus.rsp_result); end
        checks++; if (grant_cnt0 !== '0 || grant_cnt1 !== '0 || bus.req0_ready !== 1'b0) begin failures++;
            $display("FAIL async_reset_cnt: got %h/%h ready0=%b expected 0/0 ready0=0", grant_cnt0, grant_cnt1, bus.req0_ready); end
        @(posedge clock);
        #1;
        reset = 1'b0;
        model_reset();
        set_in(0, '0, '0, 1, 32'h0000_0003, 5'd2, 1);
        step();
        checks++; if (obs_rdy1 !== 1'b1 || bus.rsp_id !== 1'b1 || bus.rsp_result !== 32'h0000_000c) begin failures++;
            $display("FAIL post_reset_req1: got ready1=%b id=%b result=%h expected 1 1 0000000c", obs_rdy1, bus.rsp_id, bus.rsp_result); end
        set_in(1, 32'h1, 5'd1, 1, 32'h1, 5'd2, 1);
        step();
        checks++; if (obs_rdy0 !== exp_rdy0 || obs_rdy1 !== exp_rdy1) begin failures++;
            $display("FAIL post_reset_rr: got %b%b expected %b%b", obs_rdy0, obs_rdy1, exp_rdy0, exp_rdy1); end
        drain();
    endtask

    task automatic test_saturation();
        for (int i = 0; i < 20; i++) begin
            set_in(1, $urandom, 5'($urandom_range(31)), 0, '0, '0, 1);
            step();
            checks++; if (bus.rsp_result !== m_result || grant_cnt0 !== m_cnt0[CNT_W-1:0]) begin failures++;
                $display("FAIL saturation[%0d]: got result=%h cnt0=%h expected %h %h", i, bus.rsp_result, grant_cnt0, m_result, m_cnt0[CNT_W-1:0]); end
        end
        checks++; if (grant_cnt0 !== 4'hf) begin failures++;
            $display("FAIL saturation_final: got %h expected f", grant_cnt0); end
        drain();
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            set_in($urandom_range(1), $urandom, 5'($urandom_range(31)),
                   $urandom_range(1), $urandom, 5'($urandom_range(31)),
                   ($urandom_range(3) != 0));
            step();
            checks++; if (obs_rdy0 !== exp_rdy0 || obs_rdy1 !== exp_rdy1) begin failures++;
                $display("FAIL random_ready[%0d]: got %b%b expected %b%b", i, obs_rdy0, obs_rdy1, exp_rdy0, exp_rdy1); end
            checks++; if (bus.rsp_valid !== m_valid) begin failures++;
                $display("FAIL random_valid[%0d]: got %b expected %b", i, bus.rsp_valid, m_valid); end
            if (m_valid) begin
                checks++; if (bus.rsp_id !== m_id || bus.rsp_result !== m_result) begin failures++;
                    $display("FAIL random_rsp[%0d]: got id=%b result=%h expected id=%b result=%h", i, bus.rsp_id, bus.rsp_result, m_id, m_result); end
            end
            checks++; if (grant_cnt0 !== m_cnt0[CNT_W-1:0] || grant_cnt1 !== m_cnt1[CNT_W-1:0]) begin failures++;
                $display("FAIL random_cnt[%0d]: got %h/%h expected %h/%h", i, grant_cnt0, grant_cnt1, m_cnt0[CNT_W-1:0], m_cnt1[CNT_W-1:0]); end
        end
        drain();
    endtask

    initial begin
        test_reset();
        test_single();
        test_contention();
        test_backpressure();
        test_edges();
        test_reset_mid();
        test_saturation();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
